// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 clock, frames
// 11-bit PS/2 words (start, 8 data LSB first, parity, stop) and presents the
// last two accepted bytes as a 16-bit keycode.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keycode_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        keycode_valid,
    output logic        frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          ps2_clk_meta_reg, ps2_clk_sync_reg;
    logic          ps2_data_meta_reg, ps2_data_sync_reg;
    logic          filt_clk_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          bit_event;
    logic          parity_ok;

    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_reg, parity_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic [15:0]   keycode_reg, keycode_next;
    logic          keycode_valid_reg, keycode_valid_next;
    logic          frame_err_reg, frame_err_next;

    // Two-flop synchronizers; they idle high like the PS/2 bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_meta_reg  <= 1'b1;
            ps2_clk_sync_reg  <= 1'b1;
            ps2_data_meta_reg <= 1'b1;
            ps2_data_sync_reg <= 1'b1;
        end else begin
            ps2_clk_meta_reg  <= ps2_clk;
            ps2_clk_sync_reg  <= ps2_clk_meta_reg;
            ps2_data_meta_reg <= ps2_data;
            ps2_data_sync_reg <= ps2_data_meta_reg;
        end
    end

    // Clock deglitch: the filtered level flips only after FILTER_LEN
    // consecutive synchronized samples disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_clk_reg <= 1'b1;
            filt_cnt_reg <= '0;
        end else if (ps2_clk_sync_reg != filt_clk_reg) begin
            if (filt_cnt_reg == FILT_LAST) begin
                filt_clk_reg <= ps2_clk_sync_reg;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + FW'(1);
            end
        end else begin
            filt_cnt_reg <= '0;
        end
    end

    // Bit event is the cycle in which the filtered clock commits to a 1->0 change.
    assign bit_event = filt_clk_reg && !ps2_clk_sync_reg && (filt_cnt_reg == FILT_LAST);

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity across the eight data bits and the parity bit.
    assign parity_ok = ^{shift_reg, parity_reg};
`else
    // Parity bit is captured for visibility but never gates acceptance.
    assign parity_ok = 1'b1 | (^{shift_reg, parity_reg});
`endif

    // Frame FSM state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            bit_cnt_reg       <= '0;
            shift_reg         <= '0;
            parity_reg        <= 1'b0;
            to_cnt_reg        <= '0;
            keycode_reg       <= '0;
            keycode_valid_reg <= 1'b0;
            frame_err_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            bit_cnt_reg       <= bit_cnt_next;
            shift_reg         <= shift_next;
            parity_reg        <= parity_next;
            to_cnt_reg        <= to_cnt_next;
            keycode_reg       <= keycode_next;
            keycode_valid_reg <= keycode_valid_next;
            frame_err_reg     <= frame_err_next;
        end
    end

    // Next-state logic: frame sequencing, inter-edge timeout, accept/discard.
    always_comb begin
        state_next         = state_reg;
        bit_cnt_next       = bit_cnt_reg;
        shift_next         = shift_reg;
        parity_next        = parity_reg;
        to_cnt_next        = to_cnt_reg;
        keycode_next       = keycode_reg;
        keycode_valid_next = 1'b0;
        frame_err_next     = 1'b0;

        if (state_reg == IDLE || bit_event) begin
            to_cnt_next = '0;
        end else if (to_cnt_reg == TO_LIMIT) begin
            // Stalled mid-frame: abandon the partial byte.
            state_next     = IDLE;
            bit_cnt_next   = '0;
            to_cnt_next    = '0;
            frame_err_next = 1'b1;
        end else begin
            to_cnt_next = to_cnt_reg + TW'(1);
        end

        if (bit_event) begin
            case (state_reg)
                IDLE: begin
                    if (!ps2_data_sync_reg) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next   = {ps2_data_sync_reg, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    parity_next = ps2_data_sync_reg;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next   = IDLE;
                    bit_cnt_next = '0;
                    if (ps2_data_sync_reg && parity_ok) begin
                        keycode_next       = {keycode_reg[7:0], shift_reg};
                        keycode_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign keycode       = keycode_reg;
    assign keycode_valid = keycode_valid_reg;
    assign frame_err     = frame_err_reg;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed testbench for ps2_keycode_rx: bit-banged PS/2 frames with
// hand-computed keycodes, glitch, timeout and reset scenarios.
module tb_ps2_keycode_rx;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] keycode;
    logic        keycode_valid;
    logic        frame_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int last_valid_cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;

    ps2_keycode_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .keycode      (keycode),
        .keycode_valid(keycode_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the inactive edge.
    always @(negedge clk) begin
        if (keycode_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if (keycode_valid && frame_err) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clk(10);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        wait_clk(20);
        ps2_clk = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
        ps2_data = 1'b1;
        wait_clk(20);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(4);
        total_cnt++;
        if (keycode !== 16'h0000) $display("FAIL reset_keycode got=%h want=0000", keycode);
        else pass_cnt++;
        total_cnt++;
        if (keycode_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", keycode_valid);
        else pass_cnt++;
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL reset_err got=%b want=0", frame_err);
        else pass_cnt++;
        rst = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_single_frame();
        int v0, e0, lat;
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        lat = last_valid_cyc - fall_cyc;
        $display("frame 0x1C: keycode=%h valid_pulses=%0d latency=%0d", keycode, valid_cnt - v0, lat);
        total_cnt++;
        if (keycode !== 16'h001C) $display("FAIL single_keycode got=%h want=001C", keycode);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 1) $display("FAIL single_valid_cycles got=%0d want=1", valid_cnt - v0);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt - e0 !== 0) $display("FAIL single_err got=%0d want=0", err_cnt - e0);
        else pass_cnt++;
        total_cnt++;
        if (lat < 5 || lat > 8) $display("FAIL single_latency got=%0d want=5..8", lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int v0;
        do_reset();
        v0 = valid_cnt;
        send_frame(8'hF0, 1'b1, 1'b1);
        $display("frame 0xF0: keycode=%h", keycode);
        total_cnt++;
        if (keycode !== 16'h00F0) $display("FAIL b2b_first got=%h want=00F0", keycode);
        else pass_cnt++;
        send_frame(8'h1C, 1'b0, 1'b1);
        $display("frame 0x1C: keycode=%h", keycode);
        total_cnt++;
        if (keycode !== 16'hF01C) $display("FAIL b2b_second got=%h want=F01C", keycode);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 2) $display("FAIL b2b_valid_count got=%0d want=2", valid_cnt - v0);
        else pass_cnt++;
    endtask

    task automatic test_parity();
        int v0, e0;
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        $display("frame 0x1C bad parity: keycode=%h valid=%0d err=%0d", keycode, valid_cnt - v0, err_cnt - e0);
`ifdef PS2_PARITY_CHECK_EN
        total_cnt++;
        if (keycode !== 16'h0000) $display("FAIL parity_keycode got=%h want=0000", keycode);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt - e0 !== 1) $display("FAIL parity_err got=%0d want=1", err_cnt - e0);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 0) $display("FAIL parity_valid got=%0d want=0", valid_cnt - v0);
        else pass_cnt++;
`else
        total_cnt++;
        if (keycode !== 16'h001C) $display("FAIL parity_keycode got=%h want=001C", keycode);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt - e0 !== 0) $display("FAIL parity_err got=%0d want=0", err_cnt - e0);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 1) $display("FAIL parity_valid got=%0d want=1", valid_cnt - v0);
        else pass_cnt++;
`endif
    endtask

    task automatic test_stop_error();
        int v0, e0;
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b1);
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h23, 1'b0, 1'b0);
        $display("frame 0x23 stop=0: keycode=%h err=%0d", keycode, err_cnt - e0);
        total_cnt++;
        if (keycode !== 16'h001C) $display("FAIL stop_keycode got=%h want=001C", keycode);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt - e0 !== 1) $display("FAIL stop_err got=%0d want=1", err_cnt - e0);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 0) $display("FAIL stop_valid got=%0d want=0", valid_cnt - v0);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int e0;
        do_reset();
        e0 = err_cnt;
        ps2_data = 1'b0;
        wait_clk(10);
        ps2_clk = 1'b0;
        wait_clk(2);
        ps2_clk = 1'b1;
        wait_clk(10);
        ps2_data = 1'b1;
        wait_clk(10);
        send_frame(8'h23, 1'b0, 1'b1);
        $display("glitch then 0x23: keycode=%h err=%0d", keycode, err_cnt - e0);
        total_cnt++;
        if (keycode !== 16'h0023) $display("FAIL glitch_keycode got=%h want=0023", keycode);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt - e0 !== 0) $display("FAIL glitch_err got=%0d want=0", err_cnt - e0);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int e0, v0;
        do_reset();
        e0 = err_cnt; v0 = valid_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        wait_clk(TIMEOUT_CYCLES + 200);
        $display("stall after 5 bits: err=%0d", err_cnt - e0);
        total_cnt++;
        if (err_cnt - e0 !== 1) $display("FAIL timeout_err got=%0d want=1", err_cnt - e0);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 0) $display("FAIL timeout_valid got=%0d want=0", valid_cnt - v0);
        else pass_cnt++;
        send_frame(8'h23, 1'b0, 1'b1);
        $display("after timeout 0x23: keycode=%h", keycode);
        total_cnt++;
        if (keycode !== 16'h0023) $display("FAIL timeout_next_keycode got=%h want=0023", keycode);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        int e0;
        do_reset();
        send_frame(8'hF0, 1'b1, 1'b1);
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2_data = 1'b1;
        rst = 1'b1;
        wait_clk(3);
        $display("reset mid-frame: keycode=%h valid=%b err=%b", keycode, keycode_valid, frame_err);
        total_cnt++;
        if (keycode !== 16'h0000) $display("FAIL midrst_keycode got=%h want=0000", keycode);
        else pass_cnt++;
        rst = 1'b0;
        wait_clk(TIMEOUT_CYCLES + 100);
        total_cnt++;
        if (err_cnt - e0 !== 0) $display("FAIL midrst_err got=%0d want=0", err_cnt - e0);
        else pass_cnt++;
        send_frame(8'h1C, 1'b0, 1'b1);
        $display("after mid-frame reset 0x1C: keycode=%h", keycode);
        total_cnt++;
        if (keycode !== 16'h001C) $display("FAIL midrst_next_keycode got=%h want=001C", keycode);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity();
        test_stop_error();
        test_glitch();
        test_timeout();
        test_reset_midframe();
        total_cnt++;
        if (overlap_cnt !== 0) $display("FAIL valid_err_overlap got=%0d want=0", overlap_cnt);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_rx.md
PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: consecutive identical ps2_clk samples needed to change the filtered clock level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65000: clk cycles allowed between falling edges inside a frame.
REQ-003 SHALL have port clk, input, 1, system clock; one clock domain only.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port ps2_clk, input, 1, raw PS/2 clock pin, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1, raw PS/2 data pin, asynchronous to clk.
REQ-007 SHALL have port keycode, output, 16, {previous byte, latest byte}, consumed by the movement and reset key decoders.
REQ-008 SHALL have port keycode_valid, output, 1, single-cycle pulse when keycode updates.
REQ-009 SHALL have port frame_err, output, 1, single-cycle pulse when a frame is discarded.

Function
REQ-010 SHALL pass ps2_clk and ps2_data each through a two-flop synchronizer before any other use.
REQ-011 SHALL change the filtered clock only after FILTER_LEN consecutive synchronized samples differ from its current level; shorter pulses are ignored.
REQ-012 SHALL sample synchronized ps2_data in the cycle the filtered clock goes from 1 to 0 (bit event).
REQ-013 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: a bit event with data=0 (start bit) goes to DATA with bit count 0; a bit event with data=1 is ignored and stays in IDLE.
REQ-015 DATA: each bit event shifts in one bit, LSB first; after the 8th bit goes to PARITY.
REQ-016 PARITY: the bit event captures the parity bit and goes to STOP.
REQ-017 STOP: the bit event checks the stop bit and always returns to IDLE.
REQ-018 Frame accepted when stop=1 and the parity rule holds (REQ-031/032).
REQ-019 On accept: keycode <= {keycode[7:0], byte} and keycode_valid=1, both registered and visible in the cycle after the STOP bit event (latency 1 clk).
REQ-020 A stop bit of 0 SHALL discard the frame in all configurations: frame_err pulses one cycle, keycode unchanged.
REQ-021 Timeout counter SHALL clear on each bit event and in IDLE.
REQ-022 If the state is not IDLE and the counter reaches TIMEOUT_CYCLES: go to IDLE, pulse frame_err, discard the partial byte.
REQ-023 If timeout and a bit event occur in the same cycle, the bit event wins and the counter clears.
REQ-024 keycode_valid and frame_err SHALL never be high in the same cycle.
REQ-025 keycode SHALL hold its value between accepts; there is no wrap handling beyond the 16-bit shift.

Reset
REQ-026 During rst: state=IDLE, bit count=0, timeout counter=0, shift register=0.
REQ-027 During rst: keycode=16'h0000, keycode_valid=0, frame_err=0.
REQ-028 During rst: synchronizer flops and filtered clock = 1 (PS/2 idle level).
REQ-029 A reset mid-frame SHALL drop the partial frame silently, with no frame_err pulse.
REQ-030 After reset release, the first bit event is treated from IDLE.

Configuration
REQ-031 With PS2_PARITY_CHECK_EN defined: odd parity is required (data bits plus parity bit contain an odd number of ones); on a mismatch the frame is discarded, frame_err pulses, and keycode is unchanged.
REQ-032 Without PS2_PARITY_CHECK_EN: the parity bit is captured but ignored, and any frame with stop=1 is accepted.

Verification
REQ-033 Frame 0x1C with parity 0 and stop 1 -> keycode=16'h001C, keycode_valid high exactly 1 cycle, frame_err stays 0.
REQ-034 Frames 0xF0 then 0x1C -> keycode 16'h00F0, then 16'hF01C; two valid pulses in total.
REQ-035 Frame 0x1C with parity 1 -> with the macro: frame_err pulse, no valid, keycode=0x0000; without the macro: keycode=16'h001C with a valid pulse.
REQ-036 A 2-cycle low glitch on ps2_clk (FILTER_LEN=4) while in IDLE with data=0 -> state stays IDLE, and a following clean 0x23 frame gives keycode=16'h0023.
REQ-037 Stall after 5 data bits for TIMEOUT_CYCLES -> one frame_err pulse, return to IDLE; the next clean 0x23 frame gives keycode=16'h0023.
REQ-038 Assert rst after the 4th data bit of 0x1C -> outputs 0 with no frame_err; after release, a clean 0x1C frame gives keycode=16'h001C.
